// File: rtl/rename_register_file_if.sv
// Dispatcher / reorder-buffer side bus of the rename register file.
// The master modport is the core side (dispatcher + RoB); the slave modport
// is the register file itself.
interface rename_register_file_if #(
   parameter int unsigned REG_WIDTH    = 5,
   parameter int unsigned EX_REG_WIDTH = 6,
   parameter int unsigned RoB_WIDTH    = 8,
   parameter int unsigned EX_RoB_WIDTH = 9
);
   // dispatcher source queries and destination rename
   logic [REG_WIDTH-1:0]    DPRF_rs1;
   logic [REG_WIDTH-1:0]    DPRF_rs2;
   logic                    DPRF_en;
   logic [EX_REG_WIDTH-1:0] DPRF_rd;
   logic [RoB_WIDTH-1:0]    DPRF_RoB_index;
   // query answers
   logic [EX_RoB_WIDTH-1:0] RFDP_Qj;
   logic [EX_RoB_WIDTH-1:0] RFDP_Qk;
   logic [31:0]             RFDP_Vj;
   logic [31:0]             RFDP_Vk;
   // reorder-buffer commit and flush
   logic                    RoBRF_en;
   logic [RoB_WIDTH-1:0]    RoBRF_RoB_index;
   logic [EX_REG_WIDTH-1:0] RoBRF_rd;
   logic [31:0]             RoBRF_value;
   logic                    RoBRF_flush;

   modport master (
      output DPRF_rs1, DPRF_rs2, DPRF_en, DPRF_rd, DPRF_RoB_index,
      output RoBRF_en, RoBRF_RoB_index, RoBRF_rd, RoBRF_value, RoBRF_flush,
      input  RFDP_Qj, RFDP_Qk, RFDP_Vj, RFDP_Vk
   );

   modport slave (
      input  DPRF_rs1, DPRF_rs2, DPRF_en, DPRF_rd, DPRF_RoB_index,
      input  RoBRF_en, RoBRF_RoB_index, RoBRF_rd, RoBRF_value, RoBRF_flush,
      output RFDP_Qj, RFDP_Qk, RFDP_Vj, RFDP_Vk
   );
endinterface

// File: rtl/rename_register_file.sv
// Architectural register file with per-register rename tags.
// Holds committed values plus the RoB entry that will next write each
// register, and answers two combinational source-operand queries.
module rename_register_file #(
   parameter int unsigned             REG_WIDTH    = 5,
   parameter int unsigned             EX_REG_WIDTH = 6,
   parameter logic [EX_REG_WIDTH-1:0] NON_REG      = 6'b100000,
   parameter int unsigned             RoB_WIDTH    = 8,
   parameter int unsigned             EX_RoB_WIDTH = 9,
   parameter logic [EX_RoB_WIDTH-1:0] NON_DEP      = 9'b100000000
) (
   input logic                    Sys_clk,
   input logic                    Sys_rst,
   input logic                    Sys_rdy,
   rename_register_file_if.slave  bus
);

   typedef struct packed {
      logic [EX_RoB_WIDTH-1:0] q;
      logic [31:0]             v;
   } query_t;

   logic [31:0]             value_q [32];
   logic [EX_RoB_WIDTH-1:0] tag_q   [32];

   logic                    commit_valid;
   logic                    rename_valid;
   logic [REG_WIDTH-1:0]    commit_reg;
   logic [REG_WIDTH-1:0]    rename_reg;
   logic [EX_RoB_WIDTH-1:0] commit_tag;
   logic [EX_RoB_WIDTH-1:0] rename_tag;
   query_t                  ans_j;
   query_t                  ans_k;

   // decode commit / rename: x0 and the "no register" code never update state
   always_comb begin
      commit_valid = bus.RoBRF_en && (bus.RoBRF_rd != NON_REG) && (bus.RoBRF_rd != '0);
      rename_valid = bus.DPRF_en && !bus.RoBRF_flush &&
                     (bus.DPRF_rd != NON_REG) && (bus.DPRF_rd != '0);
      commit_reg   = bus.RoBRF_rd[REG_WIDTH-1:0];
      rename_reg   = bus.DPRF_rd[REG_WIDTH-1:0];
      commit_tag   = {1'b0, bus.RoBRF_RoB_index};
      rename_tag   = {1'b0, bus.DPRF_RoB_index};
   end

   // value/tag array update: flush beats rename beats the commit's tag clear
   always_ff @(posedge Sys_clk or negedge Sys_rst) begin
      if (!Sys_rst) begin
         for (int unsigned i = 0; i < 32; i++) begin
            value_q[i] <= '0;
            tag_q[i]   <= NON_DEP;
         end
      end else if (Sys_rdy) begin
         for (int unsigned i = 1; i < 32; i++) begin
            if (commit_valid && commit_reg == REG_WIDTH'(i))
               value_q[i] <= bus.RoBRF_value;
            if (bus.RoBRF_flush)
               tag_q[i] <= NON_DEP;
            else if (rename_valid && rename_reg == REG_WIDTH'(i))
               tag_q[i] <= rename_tag;
            else if (commit_valid && commit_reg == REG_WIDTH'(i) && tag_q[i] == commit_tag)
               tag_q[i] <= NON_DEP;
         end
      end
   end

   // One source lookup. The commit bypass only fires on a pending tag, so
   // comparing the low RoB_WIDTH bits is enough.
   function automatic query_t lookup(input logic [REG_WIDTH-1:0] rs);
      query_t r;
      r.q = NON_DEP;
      r.v = '0;
      if (rs == '0) begin
         r.q = NON_DEP;
      end else if (tag_q[rs] == NON_DEP) begin
         r.v = value_q[rs];
      end else if (bus.RoBRF_en && bus.RoBRF_rd == EX_REG_WIDTH'(rs) &&
                   tag_q[rs][RoB_WIDTH-1:0] == bus.RoBRF_RoB_index) begin
         r.v = bus.RoBRF_value;
      end else begin
         r.q = tag_q[rs];
      end
      return r;
   endfunction

   // combinational source-operand queries against pre-rename state
   always_comb begin
      ans_j       = lookup(bus.DPRF_rs1);
      ans_k       = lookup(bus.DPRF_rs2);
      bus.RFDP_Qj = ans_j.q;
      bus.RFDP_Vj = ans_j.v;
      bus.RFDP_Qk = ans_k.q;
      bus.RFDP_Vk = ans_k.v;
   end

endmodule

// File: tb/tb_rename_register_file.sv
// Directed scoreboard bench for rename_register_file.
module tb_rename_register_file;

   localparam logic [8:0] NON_DEP = 9'b100000000;
   localparam logic [5:0] NON_REG = 6'b100000;

   typedef struct {
      string       name;
      bit          port_k;
      logic [8:0]  q;
      logic [31:0] v;
   } exp_t;

   logic   Sys_clk;
   logic   Sys_rst;
   logic   Sys_rdy;
   exp_t   sb[$];
   int     checks;
   int     failures;

   rename_register_file_if #(
      .REG_WIDTH(5), .EX_REG_WIDTH(6), .RoB_WIDTH(8), .EX_RoB_WIDTH(9)
   ) bus ();

   rename_register_file #(
      .REG_WIDTH(5), .EX_REG_WIDTH(6), .NON_REG(NON_REG),
      .RoB_WIDTH(8), .EX_RoB_WIDTH(9), .NON_DEP(NON_DEP)
   ) dut (
      .Sys_clk(Sys_clk),
      .Sys_rst(Sys_rst),
      .Sys_rdy(Sys_rdy),
      .bus(bus)
   );

   initial Sys_clk = 1'b0;
   always #5 Sys_clk = ~Sys_clk;

   task automatic expect_j(input string name, input logic [8:0] q, input logic [31:0] v);
      sb.push_back('{name: name, port_k: 1'b0, q: q, v: v});
   endtask

   task automatic expect_k(input string name, input logic [8:0] q, input logic [31:0] v);
      sb.push_back('{name: name, port_k: 1'b1, q: q, v: v});
   endtask

   // drain the scoreboard against the current combinational outputs
   task automatic check_outputs();
      exp_t        e;
      logic [8:0]  q_obs;
      logic [31:0] v_obs;
      while (sb.size() > 0) begin
         e     = sb.pop_front();
         q_obs = e.port_k ? bus.RFDP_Qk : bus.RFDP_Qj;
         v_obs = e.port_k ? bus.RFDP_Vk : bus.RFDP_Vj;
         checks++;
         assert (q_obs === e.q) else begin
            failures++;
            $error("FAIL %s.Q observed=%h expected=%h", e.name, q_obs, e.q);
         end
         checks++;
         assert (v_obs === e.v) else begin
            failures++;
            $error("FAIL %s.V observed=%h expected=%h", e.name, v_obs, e.v);
         end
      end
   endtask

   task automatic next_cycle();
      @(negedge Sys_clk);
      bus.DPRF_en     = 1'b0;
      bus.RoBRF_en    = 1'b0;
      bus.RoBRF_flush = 1'b0;
   endtask

   task automatic rename(input logic [5:0] rd, input logic [7:0] idx);
      bus.DPRF_en        = 1'b1;
      bus.DPRF_rd        = rd;
      bus.DPRF_RoB_index = idx;
   endtask

   task automatic commit(input logic [5:0] rd, input logic [7:0] idx, input logic [31:0] val);
      bus.RoBRF_en        = 1'b1;
      bus.RoBRF_rd        = rd;
      bus.RoBRF_RoB_index = idx;
      bus.RoBRF_value     = val;
   endtask

   initial begin
      logic [4:0]  fr [8];
      logic [31:0] fv [8];
      fr = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};
      fv = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 32'h11, 32'h22, 32'h77};
      checks   = 0;
      failures = 0;
      Sys_rst  = 1'b0;
      Sys_rdy  = 1'b1;
      bus.DPRF_rs1 = '0; bus.DPRF_rs2 = '0; bus.DPRF_en = 1'b0;
      bus.DPRF_rd = '0; bus.DPRF_RoB_index = '0;
      bus.RoBRF_en = 1'b0; bus.RoBRF_RoB_index = '0; bus.RoBRF_rd = '0;
      bus.RoBRF_value = '0; bus.RoBRF_flush = 1'b0;

      // reset state
      repeat (2) @(negedge Sys_clk);
      bus.DPRF_rs1 = 5'd5; bus.DPRF_rs2 = 5'd31;
      #1;
      expect_j("reset_rs1", NON_DEP, 32'h0);
      expect_k("reset_rs2", NON_DEP, 32'h0);
      check_outputs();
      Sys_rst = 1'b1;

      // rename x5 -> 7; query sees the pre-rename mapping
      next_cycle();
      rename(6'd5, 8'd7); bus.DPRF_rs1 = 5'd5;
      #1; expect_j("rename_same_cycle", NON_DEP, 32'h0); check_outputs();
      next_cycle();
      bus.DPRF_rs1 = 5'd5;
      #1; expect_j("rename_visible", 9'h007, 32'h0); check_outputs();
      next_cycle();
      commit(6'd5, 8'd7, 32'hDEADBEEF);
      #1; expect_j("commit_bypass", NON_DEP, 32'hDEADBEEF); check_outputs();
      next_cycle();
      #1; expect_j("commit_array", NON_DEP, 32'hDEADBEEF); check_outputs();

      // stale commit keeps the younger tag
      next_cycle(); rename(6'd6, 8'd2);
      next_cycle(); rename(6'd6, 8'd4);
      next_cycle(); commit(6'd6, 8'd2, 32'h11); bus.DPRF_rs2 = 5'd6;
      #1; expect_k("stale_bypass", 9'h004, 32'h0); check_outputs();
      next_cycle();
      #1; expect_k("stale_after", 9'h004, 32'h0); check_outputs();

      // same-cycle commit and rename on x8
      next_cycle(); rename(6'd8, 8'd1);
      next_cycle(); commit(6'd8, 8'd1, 32'h22); rename(6'd8, 8'd9); bus.DPRF_rs1 = 5'd8;
      #1; expect_j("collide_bypass", NON_DEP, 32'h22); check_outputs();
      next_cycle();
      #1; expect_j("collide_after", 9'h009, 32'h0); check_outputs();

      // flush drops all tags and a same-cycle rename; commit value still lands
      next_cycle(); rename(6'd1, 8'd10);
      next_cycle(); rename(6'd2, 8'd11);
      next_cycle(); rename(6'd3, 8'd12); bus.DPRF_rs1 = 5'd1; bus.DPRF_rs2 = 5'd2;
      #1; expect_j("pre_flush_x1", 9'h00A, 32'h0); expect_k("pre_flush_x2", 9'h00B, 32'h0);
      check_outputs();
      next_cycle();
      bus.RoBRF_flush = 1'b1; rename(6'd4, 8'd13); commit(6'd9, 8'd50, 32'h77);
      bus.DPRF_rs2 = 5'd3;
      #1; expect_k("pre_flush_x3", 9'h00C, 32'h0); check_outputs();
      for (int i = 0; i < 8; i++) begin
         next_cycle();
         bus.DPRF_rs1 = fr[i];
         #1; expect_j($sformatf("flush_x%0d", fr[i]), NON_DEP, fv[i]); check_outputs();
      end

      // Sys_rdy low freezes state
      next_cycle();
      Sys_rdy = 1'b0; rename(6'd10, 8'd5); commit(6'd11, 8'd6, 32'h33);
      next_cycle();
      Sys_rdy = 1'b1; bus.DPRF_rs1 = 5'd10; bus.DPRF_rs2 = 5'd11;
      #1; expect_j("rdy_low_rename", NON_DEP, 32'h0); expect_k("rdy_low_commit", NON_DEP, 32'h0);
      check_outputs();

      // x0 and NON_REG never change state
      next_cycle(); rename(6'd0, 8'd20);
      next_cycle(); rename(NON_REG, 8'd21);
      next_cycle(); commit(6'd0, 8'd0, 32'h55); bus.DPRF_rs1 = 5'd0;
      #1; expect_j("x0_commit_bypass", NON_DEP, 32'h0); check_outputs();
      next_cycle(); commit(NON_REG, 8'd21, 32'h66);
      next_cycle();
      bus.DPRF_rs1 = 5'd0; bus.DPRF_rs2 = 5'd5;
      #1; expect_j("x0_after", NON_DEP, 32'h0); expect_k("x5_unchanged", NON_DEP, 32'hDEADBEEF);
      check_outputs();

      // asynchronous reset mid-run
      next_cycle(); rename(6'd5, 8'd3);
      next_cycle(); bus.DPRF_rs1 = 5'd5; bus.DPRF_rs2 = 5'd6;
      #1; expect_j("pre_reset_x5", 9'h003, 32'h0); expect_k("pre_reset_x6", NON_DEP, 32'h11);
      check_outputs();
      #1; Sys_rst = 1'b0;
      #1; expect_j("async_reset_x5", NON_DEP, 32'h0); expect_k("async_reset_x6", NON_DEP, 32'h0);
      check_outputs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
